// File: rtl/fechadura_pkg.sv
// Shared types and constants for the matrix keypad scanner: FSM states,
// the 4x4 key map and small decode helpers.
package fechadura_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } kp_state_e;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Indexed as KEY_MAP[row][col]; the last row is listed first.
    localparam logic [3:0][3:0][3:0] KEY_MAP = {
        {4'hD, KEY_HASH, 4'h0, KEY_STAR},
        {4'hC, 4'h9,     4'h8, 4'h7},
        {4'hB, 4'h6,     4'h5, 4'h4},
        {4'hA, 4'h3,     4'h2, 4'h1}
    };

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic is_one_cold(input logic [3:0] lin);
        case (lin)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] low_row(input logic [3:0] lin);
        case (lin)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones because
// the keypad lines idle high through their pull-ups.
module sync_2ff #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture of the raw lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/matricial_keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and multi-key reject.
// Define KEYPAD_REPEAT_EN to enable auto-repeat of key_valid while a key is held.
module matricial_keypad_scanner
    import fechadura_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES   = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] matricial_lin,
    output logic [3:0] matricial_col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [15:0] DB_LAST     = 16'(DEBOUNCE_CYCLES - 1);
`ifdef KEYPAD_REPEAT_EN
    // First repeat after 500 held cycles; reloading to 400 gives a 100-cycle period.
    localparam logic [15:0] REPEAT_LAST   = 16'd499;
    localparam logic [15:0] REPEAT_RELOAD = 16'd400;
`endif

    logic [3:0]  lin_s;
    logic        all_high_s;
    kp_state_e   state_q, state_d;
    logic [1:0]  col_idx_q, col_idx_d;
    logic [7:0]  settle_q, settle_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  row_q, row_d;
    logic [3:0]  lin_q, lin_d;
    logic [3:0]  col_q, col_d;
    logic        key_valid_q, key_valid_d;
    logic [3:0]  key_code_q, key_code_d;
    logic        key_held_q, key_held_d;

    sync_2ff #(.WIDTH(4)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (matricial_lin),
        .q_o (lin_s)
    );

    assign all_high_s = (lin_s == 4'b1111);

    // Next-state and output decode for the scan/debounce FSM.
    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        settle_d    = settle_q;
        cnt_d       = cnt_q;
        row_d       = row_q;
        lin_d       = lin_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        case (state_q)
            SCAN: begin
                if (settle_q >= SETTLE_LAST) begin
                    settle_d = 8'd0;
                    if (all_high_s) begin
                        col_idx_d = col_idx_q + 2'd1;
                    end else if (is_one_cold(lin_s)) begin
                        row_d   = low_row(lin_s);
                        lin_d   = lin_s;
                        cnt_d   = 16'd0;
                        state_d = DEBOUNCE;
                    end else begin
                        cnt_d   = 16'd0;
                        state_d = RELEASE;
                    end
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            DEBOUNCE: begin
                if (lin_s == lin_q) begin
                    if (cnt_q >= DB_LAST) begin
                        key_valid_d = 1'b1;
                        key_code_d  = KEY_MAP[row_q][col_idx_q];
                        cnt_d       = 16'd0;
                        state_d     = PRESSED;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end else begin
                    cnt_d    = 16'd0;
                    settle_d = 8'd0;
                    state_d  = SCAN;
                end
            end
            PRESSED: begin
                if (all_high_s) begin
                    cnt_d   = 16'd0;
                    state_d = RELEASE;
                end else begin
`ifdef KEYPAD_REPEAT_EN
                    if (cnt_q >= REPEAT_LAST) begin
                        key_valid_d = 1'b1;
                        cnt_d       = REPEAT_RELOAD;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
`else
                    cnt_d = cnt_q;
`endif
                end
            end
            RELEASE: begin
                if (all_high_s) begin
                    if (cnt_q >= DB_LAST) begin
                        cnt_d     = 16'd0;
                        settle_d  = 8'd0;
                        col_idx_d = col_idx_q + 2'd1;
                        state_d   = SCAN;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end else begin
                    cnt_d = 16'd0;
                end
            end
            default: begin
                cnt_d     = 16'd0;
                settle_d  = 8'd0;
                col_idx_d = 2'd0;
                state_d   = SCAN;
            end
        endcase
        col_d      = ~(4'b0001 << col_idx_d);
        key_held_d = (state_d == PRESSED);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SCAN;
            col_idx_q   <= 2'd0;
            settle_q    <= 8'd0;
            cnt_q       <= 16'd0;
            row_q       <= 2'd0;
            lin_q       <= 4'b1111;
            col_q       <= 4'b1110;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            settle_q    <= settle_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            lin_q       <= lin_d;
            col_q       <= col_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
        end
    end

    assign matricial_col = col_q;
    assign key_valid     = key_valid_q;
    assign key_code      = key_code_q;
    assign key_held      = key_held_q;

endmodule

// File: doc/matricial_keypad_scanner.md
MATRICIAL_KEYPAD_SCANNER -- requirements
Module: matricial_keypad_scanner

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, clk cycles each column is driven before the lines are sampled (range 2..255).
REQ-002 Parameter DEBOUNCE_CYCLES, default 20, consecutive stable samples required to accept a press or a release (range 1..65535).
REQ-003 clk  input  1  single clock, the divided system clock; one clock, reset synchronous active-high.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 matricial_lin  input  4  keypad row lines, active-low, externally pulled up.
REQ-006 matricial_col  output  4  keypad column drive, active-low one-cold.
REQ-007 key_valid  output  1  one-cycle pulse: key_code holds a newly accepted key.
REQ-008 key_code  output  4  key code; valid while key_valid=1 and held until the next accepted key.
REQ-009 key_held  output  1  high while an accepted key remains pressed.

Function
REQ-010 matricial_lin SHALL pass through a 2-flop synchronizer before use, adding 2 cycles of latency.
REQ-011 FSM states SHALL be SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-012 SCAN: drive column c (c=0..3, c=0 being matricial_col[0]) low for SETTLE_CYCLES, then sample the lines; if all high, advance c modulo 4 (3 wraps to 0).
REQ-013 SCAN: exactly one line low at the sample point -> latch row/col, freeze the column, go to DEBOUNCE with counter cleared.
REQ-014 SCAN: two or more lines low -> go to RELEASE without output (multi-key reject).
REQ-015 DEBOUNCE: each cycle the same single line is low -> counter +1; any other pattern -> back to SCAN on the same column, counter cleared.
REQ-016 When the counter reaches DEBOUNCE_CYCLES: key_valid=1 for exactly one cycle, key_code updated that same cycle, then go to PRESSED.
REQ-017 Key map (row r, col c) -> code: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E(*),0,F(#),D.
REQ-018 PRESSED: key_held=1; column stays frozen; all lines high -> RELEASE with counter cleared.
REQ-019 RELEASE: counter counts consecutive all-high cycles; any low line clears it; reaching DEBOUNCE_CYCLES -> SCAN at column (c+1) mod 4; key_held=0 in RELEASE.
REQ-020 At most one key_valid SHALL occur per physical press unless KEYPAD_REPEAT_EN is defined.
REQ-021 Counter width SHALL be 16 bits, saturating and never wrapping.

Reset
REQ-022 rst=1 at a clock edge SHALL, in any state including mid-debounce, force SCAN, c=0, matricial_col=4'b1110, key_valid=0, key_code=0, key_held=0, counters=0, synchronizer=4'b1111.
REQ-023 A key held through reset deassertion SHALL be re-detected from SCAN with a full debounce before any pulse.

Configuration
REQ-024 Macro KEYPAD_REPEAT_EN defined: in PRESSED, after 500 cycles held, key_valid SHALL re-pulse with the same key_code every 100 cycles until release.
REQ-025 KEYPAD_REPEAT_EN undefined: no repeat logic, behaviour exactly as REQ-018.

Structure
REQ-026 Shared package fechadura_pkg SHALL hold the FSM state enum, the 4x4 key-map constant, and the codes KEY_STAR=4'hE and KEY_HASH=4'hF.
REQ-027 Sub-module sync_2ff (parameterised width) SHALL implement the synchronizer; the rest stays in one module.

Verification
REQ-028 Reset, no key -> matricial_col cycles 1110,1101,1011,0111,1110 every 4 cycles; key_valid never asserts.
REQ-029 Key '5' (row1/col1) held 100 cycles, then released -> exactly one key_valid with key_code=5, about 2+4+20 cycles after contact; key_held drops on release.
REQ-030 Row0 bounce on col0 (low 5, high 1, low 30 cycles) -> single key_valid, key_code=1, issued 20 stable cycles after the last bounce.
REQ-031 Rows 0 and 2 low together on col3 -> no key_valid; scanning resumes 20 cycles after both are released.
REQ-032 rst pulsed at debounce count 10 for key '#' -> all outputs at reset values the next cycle; key_code=F after a fresh 20-cycle debounce.
REQ-033 KEYPAD_REPEAT_EN, key 'A' held 800 cycles -> key_valid at about 26, 526, 626, 726 cycles, each with key_code=A.
